// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and the
// assembler-facing jump-target table contents.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int LUT_IDX_W_DEF  = 5;
    localparam int JUMP_LUT_DEPTH = 2 ** LUT_IDX_W_DEF;
    localparam int JT_W           = 16;

    // Targets may be wider than the PC; the ROM keeps only the low PC_W bits.
    localparam logic [JT_W-1:0] JT_1 = 16'h0040;
    localparam logic [JT_W-1:0] JT_2 = 16'h0100;
    localparam logic [JT_W-1:0] JT_3 = 16'h00A0;
    localparam logic [JT_W-1:0] JT_4 = 16'h03FF;
    localparam logic [JT_W-1:0] JT_5 = 16'h03FE;
    localparam logic [JT_W-1:0] JT_6 = 16'h0020;
    localparam logic [JT_W-1:0] JT_7 = 16'hF155;
    localparam logic [JT_W-1:0] JT_8 = 16'h0010;

endpackage

// File: rtl/fetch_ctrl_jump_lut.sv
// Combinational jump-target ROM: index -> absolute PC, unlisted entries are 0.
module jump_lut
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 5
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);

    logic [JT_W-1:0] raw;

    always_comb begin
        raw = '0;
        case (int'(idx))
            1:       raw = JT_1;
            2:       raw = JT_2;
            3:       raw = JT_3;
            4:       raw = JT_4;
            5:       raw = JT_5;
            6:       raw = JT_6;
            7:       raw = JT_7;
            8:       raw = JT_8;
            default: raw = '0;
        endcase
    end

    assign target = PC_W'(raw);

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer: start/halt FSM, skip-style branching,
// absolute jumps via jump_lut, and a saturating RUN-cycle counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int LUT_IDX_W  = 5,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 is_branch,
    input  logic                 branch_en,
    input  logic                 is_jump,
    input  logic [LUT_IDX_W-1:0] jump_idx,
    output logic [PC_W-1:0]      PC,
    output logic                 running,
    output logic                 done,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [1:0]           dbg_state
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   jump_target;

    jump_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_jump_lut (
        .idx    (jump_idx),
        .target (jump_target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                pc_d = START_PC;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // The cycle that samples halt still counts as a RUN cycle.
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (halt) begin
                    state_d = HALTED;
                end else if (is_jump) begin
                    pc_d = jump_target;
                end else if (is_branch && branch_en) begin
                    pc_d = pc_q + PC_W'(2);
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC          = pc_q;
    assign running     = (state_q == RUN);
    assign done        = (state_q == HALTED);
    assign cycle_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; a second instance with a 4-bit counter
// shares all inputs to exercise saturation.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       start, halt, is_branch, branch_en, is_jump;
  logic [4:0] jump_idx;

  logic [9:0]  PC;
  logic        running, done;
  logic [15:0] cycle_count;
  logic [1:0]  dbg_state;

  logic [9:0]  pc_s;
  logic        running_s, done_s;
  logic [3:0]  cycle_count_s;
  logic [1:0]  dbg_state_s;

  int vectors = 0;
  int miscompares = 0;

  // clock / reset block
  always #5 CLK = ~CLK;

  fetch_ctrl #(.PC_W(10), .LUT_IDX_W(5), .START_ADDR(0), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .halt(halt),
    .is_branch(is_branch), .branch_en(branch_en), .is_jump(is_jump),
    .jump_idx(jump_idx), .PC(PC), .running(running), .done(done),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  fetch_ctrl #(.PC_W(10), .LUT_IDX_W(5), .START_ADDR(0), .CNT_W(4)) dut_sat (
    .CLK(CLK), .Reset(Reset), .start(start), .halt(halt),
    .is_branch(is_branch), .branch_en(branch_en), .is_jump(is_jump),
    .jump_idx(jump_idx), .PC(pc_s), .running(running_s), .done(done_s),
    .cycle_count(cycle_count_s), .dbg_state(dbg_state_s)
  );

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_flags();
    halt = 0; is_branch = 0; branch_en = 0; is_jump = 0; jump_idx = '0;
  endtask

  task automatic start_run();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic do_jump(input logic [4:0] idx);
    is_jump = 1;
    jump_idx = idx;
    step();
    clear_flags();
  endtask

  task automatic test_reset();
    Reset = 1; start = 0;
    clear_flags();
    #12;
    vectors++;
    if (PC !== 10'h000 || running !== 1'b0 || done !== 1'b0 || cycle_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_values pc=%h run=%b done=%b cnt=%0d exp pc=000 run=0 done=0 cnt=0",
               PC, running, done, cycle_count);
    end
    vectors++;
    if (dbg_state !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    Reset = 0;
    halt = 1; is_jump = 1; jump_idx = 5'd3; is_branch = 1; branch_en = 1;
    step();
    step();
    clear_flags();
    vectors++;
    if (PC !== 10'h000 || running !== 1'b0 || dbg_state !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL idle_ignores_flags pc=%h run=%b st=%0d exp pc=000 run=0 st=0",
               PC, running, dbg_state);
    end
  endtask

  task automatic test_start();
    start_run();
    vectors++;
    if (running !== 1'b1 || PC !== 10'h000 || cycle_count !== 16'd0 || dbg_state !== 2'(RUN)) begin
      miscompares++;
      $display("FAIL start_enter_run run=%b pc=%h cnt=%0d st=%0d exp run=1 pc=000 cnt=0 st=1",
               running, PC, cycle_count, dbg_state);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (PC !== 10'(i)) begin
        miscompares++;
        $display("FAIL start_sequential pc=%h exp=%h", PC, 10'(i));
      end
    end
    vectors++;
    if (cycle_count !== 16'd3) begin
      miscompares++;
      $display("FAIL start_count cnt=%0d exp=3", cycle_count);
    end
  endtask

  task automatic test_async_reset();
    do_jump(5'd6);
    repeat (5) step();
    vectors++;
    if (PC !== 10'h025) begin
      miscompares++;
      $display("FAIL reach_025 pc=%h exp=025", PC);
    end
    #3;
    Reset = 1;
    #1;
    vectors++;
    if (PC !== 10'h000 || running !== 1'b0 || done !== 1'b0 || cycle_count !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset pc=%h run=%b done=%b cnt=%0d exp pc=000 run=0 done=0 cnt=0",
               PC, running, done, cycle_count);
    end
    #2;
    Reset = 0;
    step();
    vectors++;
    if (PC !== 10'h000 || dbg_state !== 2'(IDLE)) begin
      miscompares++;
      $display("FAIL after_reset_idle pc=%h st=%0d exp pc=000 st=0", PC, dbg_state);
    end
  endtask

  task automatic test_branch();
    start_run();
    do_jump(5'd8);
    vectors++;
    if (PC !== 10'h010) begin
      miscompares++;
      $display("FAIL jump_to_010 pc=%h exp=010", PC);
    end
    is_branch = 1; branch_en = 1;
    step();
    clear_flags();
    vectors++;
    if (PC !== 10'h012) begin
      miscompares++;
      $display("FAIL branch_skip pc=%h exp=012", PC);
    end
    do_jump(5'd8);
    is_branch = 1; branch_en = 0;
    step();
    clear_flags();
    vectors++;
    if (PC !== 10'h011) begin
      miscompares++;
      $display("FAIL branch_fall pc=%h exp=011", PC);
    end
    do_jump(5'd3);
    vectors++;
    if (PC !== 10'h0A0) begin
      miscompares++;
      $display("FAIL jump_idx3 pc=%h exp=0a0", PC);
    end
  endtask

  task automatic test_jump_priority();
    do_jump(5'd6);
    is_jump = 1; jump_idx = 5'd1; is_branch = 1; branch_en = 1;
    step();
    clear_flags();
    vectors++;
    if (PC !== 10'h040) begin
      miscompares++;
      $display("FAIL jump_over_branch pc=%h exp=040", PC);
    end
    do_jump(5'd7);
    vectors++;
    if (PC !== 10'h155) begin
      miscompares++;
      $display("FAIL jump_truncate pc=%h exp=155", PC);
    end
    do_jump(5'd20);
    vectors++;
    if (PC !== 10'h000) begin
      miscompares++;
      $display("FAIL jump_default pc=%h exp=000", PC);
    end
  endtask

  task automatic test_wrap();
    do_jump(5'd4);
    step();
    vectors++;
    if (PC !== 10'h000) begin
      miscompares++;
      $display("FAIL wrap_3ff_plus1 pc=%h exp=000", PC);
    end
    do_jump(5'd5);
    is_branch = 1; branch_en = 1;
    step();
    clear_flags();
    vectors++;
    if (PC !== 10'h000) begin
      miscompares++;
      $display("FAIL wrap_3fe_plus2 pc=%h exp=000", PC);
    end
    do_jump(5'd4);
    is_branch = 1; branch_en = 1;
    step();
    clear_flags();
    vectors++;
    if (PC !== 10'h001) begin
      miscompares++;
      $display("FAIL wrap_3ff_plus2 pc=%h exp=001", PC);
    end
  endtask

  task automatic test_halt();
    #3;
    Reset = 1;
    #2;
    Reset = 0;
    start_run();
    repeat (6) step();
    vectors++;
    if (PC !== 10'h006 || cycle_count !== 16'd6) begin
      miscompares++;
      $display("FAIL pre_halt pc=%h cnt=%0d exp pc=006 cnt=6", PC, cycle_count);
    end
    halt = 1;
    step();
    clear_flags();
    vectors++;
    if (done !== 1'b1 || running !== 1'b0 || PC !== 10'h006 || cycle_count !== 16'd7
        || dbg_state !== 2'(HALTED)) begin
      miscompares++;
      $display("FAIL halt_enter done=%b run=%b pc=%h cnt=%0d st=%0d exp done=1 run=0 pc=006 cnt=7 st=2",
               done, running, PC, cycle_count, dbg_state);
    end
    vectors++;
    if (done_s !== 1'b1 || cycle_count_s !== 4'd7) begin
      miscompares++;
      $display("FAIL halt_small done=%b cnt=%0d exp done=1 cnt=7", done_s, cycle_count_s);
    end
    is_jump = 1; jump_idx = 5'd3; is_branch = 1; branch_en = 1;
    repeat (3) step();
    clear_flags();
    vectors++;
    if (PC !== 10'h006 || cycle_count !== 16'd7 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_frozen pc=%h cnt=%0d done=%b exp pc=006 cnt=7 done=1",
               PC, cycle_count, done);
    end
    start_run();
    vectors++;
    if (PC !== 10'h000 || cycle_count !== 16'd0 || running !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL restart pc=%h cnt=%0d run=%b done=%b exp pc=000 cnt=0 run=1 done=0",
               PC, cycle_count, running, done);
    end
  endtask

  task automatic test_saturation_ignore();
    logic [9:0] exp_pc;
    exp_pc = 10'h000;
    for (int i = 1; i <= 20; i++) begin
      if (i == 8) start = 1;
      step();
      start = 0;
      exp_pc = exp_pc + 10'd1;
      vectors++;
      if (PC !== exp_pc || pc_s !== exp_pc) begin
        miscompares++;
        $display("FAIL run_seq step=%0d pc=%h pc_small=%h exp=%h", i, PC, pc_s, exp_pc);
      end
    end
    vectors++;
    if (cycle_count !== 16'd20) begin
      miscompares++;
      $display("FAIL count_20 cnt=%0d exp=20", cycle_count);
    end
    vectors++;
    if (cycle_count_s !== 4'd15 || running_s !== 1'b1 || dbg_state_s !== 2'(RUN)) begin
      miscompares++;
      $display("FAIL count_saturate cnt=%0d run=%b st=%0d exp cnt=15 run=1 st=1",
               cycle_count_s, running_s, dbg_state_s);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_async_reset();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_halt();
    test_saturation_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
